axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI slave-side responder sitting on one slave port of the crossbar, behind the arbiter's slave index mapping.
- Terminates AR/R and AW/W/B channels and drives a single-port synchronous SRAM macro.
- Serves one transaction at a time.
- Uses the same read-before-write priority as the interconnect arbitration.

Parameters:
- ID_W, 8, width of ARID/AWID/RID/BID (slave-side extended ID).
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width; fixed 4-byte beats.
- MEM_AW, 14, SRAM word-address width (depth 2^MEM_AW words).

Ports:
- clk input 1: single clock, all logic on rising edge.
- rst input 1: synchronous, active-high reset.
- ARID input ID_W: read ID.
- ARADDR input ADDR_W: read start byte address.
- ARLEN input 4: beats-1.
- ARSIZE input 3: ignored; beats are always 4 bytes.
- ARBURST input 2: 00 FIXED, 01 INCR, 10 treated as INCR.
- ARVALID input 1 / ARREADY output 1: read address handshake.
- RID output ID_W: echoed ARID.
- RDATA output DATA_W: read data.
- RRESP output 2: always 2'b00.
- RLAST output 1: final read beat.
- RVALID output 1 / RREADY input 1: read data handshake.
- AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID input / AWREADY output: write address channel, same widths and semantics as AR.
- WDATA input DATA_W: write data.
- WSTRB input 4: byte enables.
- WLAST input 1: final write beat.
- WVALID input 1 / WREADY output 1: write data handshake.
- BID output ID_W: echoed AWID.
- BRESP output 2: write response.
- BVALID output 1 / BREADY input 1: write response handshake.
- mem_cs output 1: SRAM chip select.
- mem_we output 4: per-byte write enable; 0 means read.
- mem_addr output MEM_AW: SRAM word address.
- mem_wdata output DATA_W: SRAM write data.
- mem_rdata input DATA_W: SRAM read data. Valid the cycle after a read access and held stable until the next mem_cs.

Behaviour:
- State machine: IDLE, RADDR, RDATA, WDATA, WRESP.
- Reset state: IDLE. All VALID and READY outputs 0 except ARREADY/AWREADY, which follow their IDLE equations. mem_cs 0, mem_we 0. Internal registers (ID, address, len, beat counter, error flag) cleared to 0.
- Reset asserted mid-burst: the burst is dropped silently; the next cycle is IDLE.
- ARREADY = (state==IDLE). AWREADY = (state==IDLE) && !ARVALID.
  - When ARVALID and AWVALID are both high in IDLE, the read wins.
  - AW stalls until the read burst completes and the FSM re-enters IDLE.
- IDLE, AR handshake: latch ARID, ARADDR[MEM_AW+1:2], ARLEN, ARBURST; clear beat counter; go to RADDR.
- IDLE, AW handshake: latch AW fields likewise; go to WDATA.
- RADDR (1 cycle): mem_cs=1, mem_we=0, mem_addr=current word address; go to RDATA.
- RDATA:
  - RVALID=1, RDATA=mem_rdata, RID=latched ID, RRESP=00, RLAST=(beat==len).
  - RREADY low: hold all R outputs and stay in RDATA.
  - On R handshake: if RLAST, go to IDLE. Otherwise advance the address (+1 word for INCR, unchanged for FIXED), increment beat, go to RADDR.
  - Latency: first RVALID 2 cycles after the AR handshake edge; throughput 1 beat per 2 cycles.
- Word address wraps modulo 2^MEM_AW. Upper address bits and the low 2 bits are ignored.
- WDATA: WREADY=1.
  - On each W handshake in the same cycle: mem_cs=1, mem_we=WSTRB, mem_addr=current address, mem_wdata=WDATA. Then advance address and beat counter.
  - Error flag is set if WLAST arrives with beat != len, or if beat==len and WLAST=0.
  - The burst terminates only on a WLAST handshake; then go to WRESP.
  - No W handshake in a cycle: mem_cs=0.
- WRESP: BVALID=1, BID=latched ID, BRESP = error ? 2'b10 (SLVERR) : 2'b00. On BREADY go to IDLE.
- A new AR/AW handshake is accepted no earlier than the cycle after RLAST/B handshake (IDLE for at least 1 cycle).
- WSTRB=0000 on a beat: the beat is still counted and mem_cs=1 with mem_we=0. That is a harmless read access.

Test Plan:
- Single read: preload word 0x4=0xDEADBEEF; AR addr 0x10, len 0, id 0x5A. Required: RVALID 2 cycles after handshake, RDATA=0xDEADBEEF, RLAST=1, RID=0x5A, RRESP=00, return to IDLE.
- 4-beat INCR read at 0x20, RREADY toggled 1,0,0,1. Required: mem_addr 0x8,0x9,0xA,0xB in order, R outputs held stable while RREADY=0, RLAST only on beat 4.
- 2-beat INCR write at 0x40, WDATA 0x11223344/0x55667788, WSTRB 0011/1100, word initially 0. Required: BRESP=00. Readback gives 0x00003344 at 0x40 and 0x55660000 at 0x44.
- ARVALID and AWVALID asserted in the same IDLE cycle. Required: ARREADY=1, AWREADY=0. AW is accepted in the IDLE cycle following the read's RLAST handshake.
- AWLEN=3 with WLAST on beat 2. Required: 2 writes performed, BRESP=10. FIXED read len 2 returns the same word 3 times.
- rst pulsed during beat 2 of a 4-beat read. Required: next cycle RVALID=0, ARREADY=1, and a fresh single read then completes correctly.

Source files
------------

// File: rtl/axi_sram_slave.sv
// axi_sram_slave
//   AXI slave responder for one crossbar slave port, fronting a single-port
//   synchronous SRAM. One transaction in flight; a pending read wins over a
//   pending write in IDLE.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   AR*/R*            : read address / read data channels (ID echoed on RID)
//   AW*/W*/B*         : write address / write data / write response channels
//   mem_cs, mem_we    : SRAM chip select, per-byte write enable (0 = read)
//   mem_addr          : SRAM word address (byte address bits [MEM_AW+1:2])
//   mem_wdata         : SRAM write data
//   mem_rdata         : SRAM read data, valid the cycle after a read access
module axi_sram_slave #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  input  logic [ID_W-1:0]   AWID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  output logic              mem_cs,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RADDR = 3'd1;
  localparam logic [2:0] S_RDATA = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_WRESP = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        beat_q, beat_d;
  logic [1:0]        burst_q, burst_d;
  logic              err_q, err_d;

  logic              last_beat;
  logic [MEM_AW-1:0] addr_next;

  // Size is fixed at 4 bytes and only the word-address slice is decoded.
  logic unused_inputs;
  assign unused_inputs = ^{ARSIZE, AWSIZE,
                           ARADDR[ADDR_W-1:MEM_AW+2], ARADDR[1:0],
                           AWADDR[ADDR_W-1:MEM_AW+2], AWADDR[1:0]};

  assign last_beat = (beat_q == len_q);
  // FIXED holds the address; INCR and every other encoding step one word,
  // wrapping naturally at the SRAM depth.
  assign addr_next = (burst_q == 2'b00) ? addr_q : addr_q + 1'b1;

  assign RID       = id_q;
  assign BID       = id_q;
  assign RDATA     = mem_rdata;
  assign RRESP     = 2'b00;
  assign BRESP     = err_q ? 2'b10 : 2'b00;
  assign mem_addr  = addr_q;
  assign mem_wdata = WDATA;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    burst_d = burst_q;
    err_d   = err_q;
    ARREADY = 1'b0;
    AWREADY = 1'b0;
    RVALID  = 1'b0;
    RLAST   = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    mem_cs  = 1'b0;
    mem_we  = '0;
    case (state_q)
      S_IDLE: begin
        ARREADY = 1'b1;
        AWREADY = !ARVALID;
        if (ARVALID) begin
          id_d    = ARID;
          addr_d  = ARADDR[MEM_AW+1:2];
          len_d   = ARLEN;
          burst_d = ARBURST;
          beat_d  = '0;
          state_d = S_RADDR;
        end else if (AWVALID) begin
          id_d    = AWID;
          addr_d  = AWADDR[MEM_AW+1:2];
          len_d   = AWLEN;
          burst_d = AWBURST;
          beat_d  = '0;
          err_d   = 1'b0;
          state_d = S_WDATA;
        end
      end
      S_RADDR: begin
        mem_cs  = 1'b1;
        state_d = S_RDATA;
      end
      S_RDATA: begin
        // No SRAM access here, so mem_rdata (and thus RDATA) stays put
        // for as long as RREADY is held low.
        RVALID = 1'b1;
        RLAST  = last_beat;
        if (RREADY) begin
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_next;
            beat_d  = beat_q + 1'b1;
            state_d = S_RADDR;
          end
        end
      end
      S_WDATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          mem_cs = 1'b1;
          mem_we = WSTRB;
          addr_d = addr_next;
          beat_d = beat_q + 1'b1;
          // WLAST must coincide exactly with the beat numbered AWLEN.
          if (WLAST != last_beat) begin
            err_d = 1'b1;
          end
          if (WLAST) begin
            state_d = S_WRESP;
          end
        end
      end
      S_WRESP: begin
        BVALID = 1'b1;
        if (BREADY) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      burst_q <= burst_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave
//   Directed bench for axi_sram_slave with a behavioural SRAM model.
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ARID, AWID, RID, BID;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
  logic [3:0]  ARLEN, AWLEN, WSTRB, mem_we;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        mem_cs;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_sram_slave #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .MEM_AW(14)) dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // SRAM model; preloads go through the same process to keep a single writer.
  logic [31:0] mem [0:16383];
  int          wr_count = 0;
  logic        pre_en = 1'b0;
  logic [13:0] pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_cs) begin
      if (mem_we == 4'b0000) begin
        mem_rdata <= mem[mem_addr];
      end else begin
        wr_count <= wr_count + 1;
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    @(negedge clk); pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk); pre_en = 1'b0;
  endtask

  // Read driver: results left in rd_* for the calling test to judge.
  logic [31:0] rd_data [16];
  logic [15:0] rd_last;
  logic [7:0]  rd_id;
  logic [1:0]  rd_resp;
  int          rd_beats;

  task automatic run_read(input logic [7:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst);
    @(negedge clk);
    ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
    @(posedge clk);
    @(negedge clk); ARVALID = 1'b0; RREADY = 1'b1; rd_beats = 0; rd_last = '0;
    for (int b = 0; b <= int'(len); b++) begin
      int t = 0;
      while (!RVALID && t < 10) begin @(negedge clk); t++; end
      if (!RVALID) break;
      rd_data[b] = RDATA; rd_last[b] = RLAST; rd_id = RID; rd_resp = RRESP;
      rd_beats++;
      @(negedge clk);
    end
    RREADY = 1'b0;
  endtask

  // Write driver: sends nbeats beats, WLAST on the final one.
  logic [31:0] wr_data [16];
  logic [3:0]  wr_strb [16];
  logic [1:0]  wb_resp;
  logic [7:0]  wb_id;
  logic        wb_ok;

  task automatic run_write(input logic [7:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst, input int nbeats);
    int t = 0;
    @(negedge clk);
    AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
    @(posedge clk);
    @(negedge clk); AWVALID = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      WDATA = wr_data[b]; WSTRB = wr_strb[b]; WLAST = (b == nbeats - 1); WVALID = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    while (!BVALID && t < 10) begin @(negedge clk); t++; end
    wb_ok = BVALID; wb_resp = BRESP; wb_id = BID;
    BREADY = 1'b1;
    @(negedge clk); BREADY = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; RREADY = 1'b0; BREADY = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (ARREADY !== 1'b1) begin n_err++; $display("FAIL rst_arready: got %b exp 1", ARREADY); end
    n_cmp++; if (AWREADY !== 1'b1) begin n_err++; $display("FAIL rst_awready: got %b exp 1", AWREADY); end
    n_cmp++; if ({RVALID, WREADY, BVALID} !== 3'b000) begin n_err++; $display("FAIL rst_valids: got %b exp 000", {RVALID, WREADY, BVALID}); end
    n_cmp++; if ({mem_cs, mem_we} !== 5'b0) begin n_err++; $display("FAIL rst_mem: got %b exp 00000", {mem_cs, mem_we}); end
    rst = 1'b0;
  endtask

  task automatic test_single_read;
    preload(14'h4, 32'hDEADBEEF);
    @(negedge clk);
    ARID = 8'h5A; ARADDR = 32'h10; ARLEN = 4'd0; ARBURST = 2'b01; ARVALID = 1'b1;
    @(posedge clk);
    @(negedge clk); ARVALID = 1'b0;
    n_cmp++; if (RVALID !== 1'b0) begin n_err++; $display("FAIL rd1_rvalid_early: got %b exp 0", RVALID); end
    n_cmp++; if ({mem_cs, mem_we, mem_addr} !== {1'b1, 4'b0, 14'h4}) begin n_err++; $display("FAIL rd1_mem_access: got %b %b %h exp 1 0000 0004", mem_cs, mem_we, mem_addr); end
    @(negedge clk);
    n_cmp++; if (RVALID !== 1'b1) begin n_err++; $display("FAIL rd1_rvalid: got %b exp 1", RVALID); end
    n_cmp++; if (RDATA !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd1_rdata: got %h exp deadbeef", RDATA); end
    n_cmp++; if ({RLAST, RID, RRESP} !== {1'b1, 8'h5A, 2'b00}) begin n_err++; $display("FAIL rd1_rlast_rid_rresp: got %b %h %b exp 1 5a 00", RLAST, RID, RRESP); end
    RREADY = 1'b1;
    @(negedge clk); RREADY = 1'b0;
    n_cmp++; if ({RVALID, ARREADY} !== 2'b01) begin n_err++; $display("FAIL rd1_idle: got rvalid=%b arready=%b exp 0 1", RVALID, ARREADY); end
  endtask

  task automatic test_incr_read;
    for (int i = 0; i < 4; i++) preload(14'h8 + 14'(i), 32'hA5A5_0000 + 32'(i));
    @(negedge clk);
    ARID = 8'h11; ARADDR = 32'h20; ARLEN = 4'd3; ARBURST = 2'b01; ARVALID = 1'b1;
    @(posedge clk);
    @(negedge clk); ARVALID = 1'b0;
    for (int b = 0; b < 4; b++) begin
      n_cmp++; if ({mem_cs, mem_addr} !== {1'b1, 14'h8 + 14'(b)}) begin n_err++; $display("FAIL incr_addr_beat%0d: got cs=%b addr=%h exp 1 %h", b, mem_cs, mem_addr, 14'h8 + 14'(b)); end
      @(negedge clk);
      n_cmp++; if ({RVALID, RLAST, RDATA} !== {1'b1, b == 3, 32'hA5A5_0000 + 32'(b)}) begin n_err++; $display("FAIL incr_rbeat%0d: got v=%b l=%b d=%h exp 1 %b %h", b, RVALID, RLAST, RDATA, b == 3, 32'hA5A5_0000 + 32'(b)); end
      if (b == 1) begin
        RREADY = 1'b0;
        for (int s = 0; s < 2; s++) begin
          @(negedge clk);
          n_cmp++; if ({RVALID, RLAST, RDATA, mem_cs} !== {1'b1, 1'b0, 32'hA5A5_0001, 1'b0}) begin n_err++; $display("FAIL incr_hold%0d: got v=%b l=%b d=%h cs=%b exp 1 0 a5a50001 0", s, RVALID, RLAST, RDATA, mem_cs); end
        end
      end
      RREADY = 1'b1;
      @(negedge clk); RREADY = 1'b0;
    end
    n_cmp++; if ({RVALID, ARREADY} !== 2'b01) begin n_err++; $display("FAIL incr_idle: got rvalid=%b arready=%b exp 0 1", RVALID, ARREADY); end
  endtask

  task automatic test_write;
    preload(14'h10, 32'h0); preload(14'h11, 32'h0);
    @(negedge clk);
    AWID = 8'h33; AWADDR = 32'h40; AWLEN = 4'd1; AWBURST = 2'b01; AWVALID = 1'b1;
    #1;
    n_cmp++; if (AWREADY !== 1'b1) begin n_err++; $display("FAIL wr_awready: got %b exp 1", AWREADY); end
    @(posedge clk);
    @(negedge clk); AWVALID = 1'b0;
    n_cmp++; if ({WREADY, mem_cs} !== 2'b10) begin n_err++; $display("FAIL wr_wait: got wready=%b cs=%b exp 1 0", WREADY, mem_cs); end
    WDATA = 32'h11223344; WSTRB = 4'b0011; WLAST = 1'b0; WVALID = 1'b1;
    #1;
    n_cmp++; if ({mem_cs, mem_we, mem_addr, mem_wdata} !== {1'b1, 4'b0011, 14'h10, 32'h11223344}) begin n_err++; $display("FAIL wr_beat0: got %b %b %h %h exp 1 0011 0010 11223344", mem_cs, mem_we, mem_addr, mem_wdata); end
    @(posedge clk);
    @(negedge clk);
    WDATA = 32'h55667788; WSTRB = 4'b1100; WLAST = 1'b1;
    #1;
    n_cmp++; if ({mem_cs, mem_we, mem_addr} !== {1'b1, 4'b1100, 14'h11}) begin n_err++; $display("FAIL wr_beat1: got %b %b %h exp 1 1100 0011", mem_cs, mem_we, mem_addr); end
    @(posedge clk);
    @(negedge clk); WVALID = 1'b0; WLAST = 1'b0;
    n_cmp++; if ({BVALID, BID, BRESP} !== {1'b1, 8'h33, 2'b00}) begin n_err++; $display("FAIL wr_bresp: got v=%b id=%h r=%b exp 1 33 00", BVALID, BID, BRESP); end
    BREADY = 1'b1;
    @(negedge clk); BREADY = 1'b0;
    n_cmp++; if (BVALID !== 1'b0) begin n_err++; $display("FAIL wr_bdone: got %b exp 0", BVALID); end
    run_read(8'h01, 32'h40, 4'd0, 2'b01);
    n_cmp++; if ({rd_beats, rd_data[0]} !== {32'd1, 32'h00003344}) begin n_err++; $display("FAIL wr_readback0: got beats=%0d d=%h exp 1 00003344", rd_beats, rd_data[0]); end
    run_read(8'h02, 32'h44, 4'd0, 2'b01);
    n_cmp++; if ({rd_beats, rd_data[0]} !== {32'd1, 32'h55660000}) begin n_err++; $display("FAIL wr_readback1: got beats=%0d d=%h exp 1 55660000", rd_beats, rd_data[0]); end
  endtask

  task automatic test_priority;
    @(negedge clk);
    ARID = 8'h01; ARADDR = 32'h10; ARLEN = 4'd0; ARBURST = 2'b01; ARVALID = 1'b1;
    AWID = 8'h02; AWADDR = 32'h80; AWLEN = 4'd0; AWBURST = 2'b01; AWVALID = 1'b1;
    #1;
    n_cmp++; if ({ARREADY, AWREADY} !== 2'b10) begin n_err++; $display("FAIL prio_ready: got ar=%b aw=%b exp 1 0", ARREADY, AWREADY); end
    @(posedge clk);
    @(negedge clk); ARVALID = 1'b0;
    n_cmp++; if ({AWREADY, WREADY} !== 2'b00) begin n_err++; $display("FAIL prio_aw_stall_raddr: got aw=%b w=%b exp 0 0", AWREADY, WREADY); end
    @(negedge clk);
    n_cmp++; if ({RVALID, RDATA, AWREADY} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin n_err++; $display("FAIL prio_rbeat: got v=%b d=%h aw=%b exp 1 deadbeef 0", RVALID, RDATA, AWREADY); end
    RREADY = 1'b1;
    @(negedge clk); RREADY = 1'b0;
    n_cmp++; if (AWREADY !== 1'b1) begin n_err++; $display("FAIL prio_aw_idle: got %b exp 1", AWREADY); end
    @(posedge clk);
    @(negedge clk); AWVALID = 1'b0;
    n_cmp++; if (WREADY !== 1'b1) begin n_err++; $display("FAIL prio_aw_taken: got wready=%b exp 1", WREADY); end
    WDATA = 32'hCAFEF00D; WSTRB = 4'b1111; WLAST = 1'b1; WVALID = 1'b1;
    @(posedge clk);
    @(negedge clk); WVALID = 1'b0; WLAST = 1'b0;
    n_cmp++; if ({BVALID, BID, BRESP} !== {1'b1, 8'h02, 2'b00}) begin n_err++; $display("FAIL prio_bresp: got v=%b id=%h r=%b exp 1 02 00", BVALID, BID, BRESP); end
    BREADY = 1'b1;
    @(negedge clk); BREADY = 1'b0;
    n_cmp++; if (mem[14'h20] !== 32'hCAFEF00D) begin n_err++; $display("FAIL prio_wr_mem: got %h exp cafef00d", mem[14'h20]); end
  endtask

  task automatic test_wlast_errors;
    int c0;
    wr_data[0] = 32'h0A0A0A0A; wr_strb[0] = 4'b1111;
    wr_data[1] = 32'h0B0B0B0B; wr_strb[1] = 4'b1111;
    c0 = wr_count;
    run_write(8'h44, 32'h100, 4'd3, 2'b01, 2);
    n_cmp++; if ({wb_ok, wb_id, wb_resp} !== {1'b1, 8'h44, 2'b10}) begin n_err++; $display("FAIL early_wlast_bresp: got v=%b id=%h r=%b exp 1 44 10", wb_ok, wb_id, wb_resp); end
    n_cmp++; if (wr_count - c0 !== 2) begin n_err++; $display("FAIL early_wlast_writes: got %0d exp 2", wr_count - c0); end
    run_read(8'h45, 32'h100, 4'd2, 2'b00);
    n_cmp++; if (rd_beats !== 3) begin n_err++; $display("FAIL fixed_beats: got %0d exp 3", rd_beats); end
    for (int b = 0; b < 3; b++) begin
      n_cmp++; if ({rd_data[b], rd_last[b]} !== {32'h0A0A0A0A, b == 2}) begin n_err++; $display("FAIL fixed_beat%0d: got d=%h l=%b exp 0a0a0a0a %b", b, rd_data[b], rd_last[b], b == 2); end
    end
    run_write(8'h46, 32'h200, 4'd0, 2'b01, 2);
    n_cmp++; if ({wb_ok, wb_id, wb_resp} !== {1'b1, 8'h46, 2'b10}) begin n_err++; $display("FAIL late_wlast_bresp: got v=%b id=%h r=%b exp 1 46 10", wb_ok, wb_id, wb_resp); end
    run_write(8'h47, 32'h300, 4'd1, 2'b01, 2);
    n_cmp++; if ({wb_ok, wb_resp} !== {1'b1, 2'b00}) begin n_err++; $display("FAIL err_cleared_bresp: got v=%b r=%b exp 1 00", wb_ok, wb_resp); end
  endtask

  task automatic test_reset_mid_burst;
    @(negedge clk);
    ARID = 8'h77; ARADDR = 32'h20; ARLEN = 4'd3; ARBURST = 2'b01; ARVALID = 1'b1; RREADY = 1'b1;
    @(posedge clk);
    @(negedge clk); ARVALID = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({RVALID, RDATA} !== {1'b1, 32'hA5A5_0001}) begin n_err++; $display("FAIL midrst_beat2: got v=%b d=%h exp 1 a5a50001", RVALID, RDATA); end
    rst = 1'b1; RREADY = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    n_cmp++; if ({RVALID, ARREADY, mem_cs} !== 3'b010) begin n_err++; $display("FAIL midrst_idle: got v=%b ar=%b cs=%b exp 0 1 0", RVALID, ARREADY, mem_cs); end
    run_read(8'h78, 32'h10, 4'd0, 2'b01);
    n_cmp++; if ({rd_beats, rd_data[0], rd_last[0], rd_id, rd_resp} !== {32'd1, 32'hDEADBEEF, 1'b1, 8'h78, 2'b00}) begin n_err++; $display("FAIL midrst_fresh_read: got n=%0d d=%h l=%b id=%h r=%b exp 1 deadbeef 1 78 00", rd_beats, rd_data[0], rd_last[0], rd_id, rd_resp); end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_incr_read;
    test_write;
    test_priority;
    test_wlast_errors;
    test_reset_mid_burst;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
